gmii_tx_framer: RTL

//  GMII transmit framer; sits directly upstream of the GMII->RGMII DDR output stage.
//  - Input: a byte stream using a valid/ready/last handshake.
//  - Output: a complete Ethernet frame on GMII: preamble, SFD, payload, zero pad, CRC-32 FCS.
//  - Enforces the minimum frame length and the inter-frame gap, and flags underrun/abort via gmii_tx_er.

---
 rtl/gmii_tx_framer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: wraps a valid/ready/last byte stream into preamble, SFD,
// payload, zero pad and CRC-32 FCS, with IFG enforcement and underrun/abort signalling.
module gmii_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 60,
  parameter int IFG_LEN      = 12
) (
  input  logic       gmii_tx_clk,
  input  logic       gmii_tx_rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  input  logic       s_err,
  output logic       s_ready,
  output logic [7:0] gmii_tx_data,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    SFD  = 3'd2,
    DATA = 3'd3,
    PAD  = 3'd4,
    FCS  = 3'd5,
    IFG  = 3'd6,
    DROP = 3'd7
  } state_t;

  localparam logic [7:0]  PRE_C = 8'(PREAMBLE_LEN);
  localparam logic [10:0] MIN_C = 11'(MIN_PAYLOAD);
  localparam logic [7:0]  IFG_C = 8'(IFG_LEN);

  // One byte of reflected CRC-32 (poly 0xEDB88320), LSB processed first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  state_t      state_r;
  logic [7:0]  pre_cnt_r;
  logic [10:0] count_r;
  logic [7:0]  ifg_cnt_r;
  logic [1:0]  fcs_idx_r;
  logic [31:0] crc_r;
  logic [10:0] cnt_inc_s;
  logic [31:0] fcs_s;
  logic [7:0]  fcs_byte_s;

  assign cnt_inc_s = (count_r == 11'h7FF) ? count_r : (count_r + 11'd1);
  assign fcs_s     = ~crc_r;

  // Select the FCS byte to emit, least significant byte first.
  always_comb begin
    fcs_byte_s = 8'h00;
    case (fcs_idx_r)
      2'd0:    fcs_byte_s = fcs_s[7:0];
      2'd1:    fcs_byte_s = fcs_s[15:8];
      2'd2:    fcs_byte_s = fcs_s[23:16];
      2'd3:    fcs_byte_s = fcs_s[31:24];
      default: fcs_byte_s = 8'h00;
    endcase
  end

  // Framing FSM; every output is registered with the value for the coming cycle.
  always_ff @(posedge gmii_tx_clk) begin
    if (!gmii_tx_rst_n) begin
      state_r      <= IDLE;
      pre_cnt_r    <= 8'd0;
      count_r      <= 11'd0;
      ifg_cnt_r    <= 8'd0;
      fcs_idx_r    <= 2'd0;
      crc_r        <= 32'hFFFFFFFF;
      s_ready      <= 1'b0;
      gmii_tx_data <= 8'h00;
      gmii_tx_en   <= 1'b0;
      gmii_tx_er   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      gmii_tx_er <= 1'b0;
      busy       <= 1'b1;
      case (state_r)
        IDLE: begin
          s_ready <= 1'b0;
          if (s_valid) begin
            state_r      <= PRE;
            pre_cnt_r    <= 8'd1;
            gmii_tx_data <= 8'h55;
            gmii_tx_en   <= 1'b1;
          end else begin
            gmii_tx_data <= 8'h00;
            gmii_tx_en   <= 1'b0;
            busy         <= 1'b0;
          end
        end
        PRE: begin
          if (pre_cnt_r < PRE_C) begin
            pre_cnt_r    <= pre_cnt_r + 8'd1;
            gmii_tx_data <= 8'h55;
          end else begin
            state_r      <= SFD;
            gmii_tx_data <= 8'hD5;
            s_ready      <= 1'b1;
            crc_r        <= 32'hFFFFFFFF;
            count_r      <= 11'd0;
          end
        end
        SFD, DATA: begin
          // A missing byte or an upstream abort both poison the frame with one TX_ER cycle.
          if (!s_valid || s_err) begin
            gmii_tx_data <= 8'h00;
            gmii_tx_er   <= 1'b1;
            if (s_valid && s_last) begin
              state_r   <= IFG;
              s_ready   <= 1'b0;
              ifg_cnt_r <= 8'd0;
            end else begin
              state_r <= DROP;
            end
          end else begin
            gmii_tx_data <= s_data;
            crc_r        <= crc32_byte(crc_r, s_data);
            count_r      <= cnt_inc_s;
            if (s_last) begin
              s_ready   <= 1'b0;
              fcs_idx_r <= 2'd0;
              state_r   <= (cnt_inc_s < MIN_C) ? PAD : FCS;
            end else begin
              state_r <= DATA;
            end
          end
        end
        PAD: begin
          gmii_tx_data <= 8'h00;
          crc_r        <= crc32_byte(crc_r, 8'h00);
          count_r      <= cnt_inc_s;
          if (cnt_inc_s >= MIN_C) begin
            state_r   <= FCS;
            fcs_idx_r <= 2'd0;
          end else begin
            state_r <= PAD;
          end
        end
        FCS: begin
          gmii_tx_data <= fcs_byte_s;
          fcs_idx_r    <= fcs_idx_r + 2'd1;
          if (fcs_idx_r == 2'd3) begin
            state_r   <= IFG;
            ifg_cnt_r <= 8'd0;
          end else begin
            state_r <= FCS;
          end
        end
        IFG: begin
          s_ready <= 1'b0;
          if (ifg_cnt_r < IFG_C) begin
            ifg_cnt_r    <= ifg_cnt_r + 8'd1;
            gmii_tx_data <= 8'h00;
            gmii_tx_en   <= 1'b0;
          end else if (s_valid) begin
            state_r      <= PRE;
            pre_cnt_r    <= 8'd1;
            gmii_tx_data <= 8'h55;
            gmii_tx_en   <= 1'b1;
          end else begin
            state_r      <= IDLE;
            gmii_tx_data <= 8'h00;
            gmii_tx_en   <= 1'b0;
            busy         <= 1'b0;
          end
        end
        DROP: begin
          gmii_tx_data <= 8'h00;
          gmii_tx_en   <= 1'b0;
          if (s_valid && s_last) begin
            state_r   <= IFG;
            s_ready   <= 1'b0;
            ifg_cnt_r <= 8'd0;
          end else begin
            state_r <= DROP;
          end
        end
        default: begin
          state_r      <= IDLE;
          s_ready      <= 1'b0;
          gmii_tx_data <= 8'h00;
          gmii_tx_en   <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
